// File: rtl/rxuart.sv
// rtl/rxuart.sv - UART receiver, 8 data bits, one stop bit, fixed CLOCKS_PER_BAUD.
// Define RXUART_PARITY_EN to expect an even-parity bit after the data bits.
module rxuart #(
  parameter logic [15:0] CLOCKS_PER_BAUD = 16'd868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam logic [15:0] HALF_BAUD = (CLOCKS_PER_BAUD >> 1) - 16'd1;
  localparam logic [15:0] BAUD_M1   = CLOCKS_PER_BAUD - 16'd1;

  typedef enum logic [3:0] {
    IDLE, START,
    BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7,
`ifdef RXUART_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        sample;
  logic        rx_q1, rx_s;
  logic [7:0]  shreg;
  logic        is_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      rx_q1 <= i_uart_rx;
      rx_s  <= rx_q1;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HALF_BAUD;
        end
      end
      // Line held low after a frame (break): no start detection until it rises.
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: begin
        if (cnt == 16'd0) begin
          sample = 1'b1;
          cnt_n  = BAUD_M1;
          case (state)
            START: state_n = rx_s ? IDLE : BIT0;
`ifdef RXUART_PARITY_EN
            BIT7:   state_n = PARITY;
            PARITY: state_n = STOP;
`else
            BIT7:   state_n = STOP;
`endif
            STOP:    state_n = rx_s ? IDLE : WAIT_HIGH;
            default: state_n = state_t'(state + 4'd1);
          endcase
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
    endcase
  end

  assign is_data = (state >= BIT0) && (state <= BIT7);

`ifdef RXUART_PARITY_EN
  logic par_bit;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (sample && state == PARITY) par_bit <= rx_s;
      if (sample && state == STOP) o_parity_err <= (^shreg) ^ par_bit;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg       <= 8'h00;
      o_wr        <= 1'b0;
      o_data      <= 8'h00;
      o_frame_err <= 1'b0;
    end else begin
      o_wr <= sample && (state == STOP);
      if (sample && is_data) shreg <= {rx_s, shreg[7:1]};
      if (sample && state == STOP) begin
        o_data      <= shreg;
        o_frame_err <= !rx_s;
      end
    end
  end

endmodule

// File: tb/tb_rxuart.sv
// tb/tb_rxuart.sv - scoreboard bench for rxuart at CLOCKS_PER_BAUD=16.
module tb_rxuart;
  localparam int CPB = 16;
`ifdef RXUART_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_parity_err;

  int passed = 0;
  int total  = 0;
  int wr_count = 0;
  int pushed = 0;
  int hold_viol = 0;
  logic [7:0] last_data = 8'h00;
  logic [9:0] expq[$];

  rxuart #(.CLOCKS_PER_BAUD(16'(CPB))) dut (
    .i_clk(clk), .i_reset(rst), .i_uart_rx(rx),
    .o_wr(o_wr), .o_data(o_data),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a received frame yields its data byte, frame error = stop bit low,
  // parity error = odd overall parity of data plus parity bit (parity builds only).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int hold, input int gap, input bit expect_wr);
    if (expect_wr) begin
`ifdef RXUART_PARITY_EN
      expq.push_back({d, ~stop, (^d) ^ par});
`else
      expq.push_back({d, ~stop, 1'b0});
`endif
      pushed++;
    end
    rx = 1'b0; clks(CPB);
    for (int i = 0; i < 8; i++) begin rx = d[i]; clks(CPB); end
`ifdef RXUART_PARITY_EN
    rx = par; clks(CPB);
`endif
    rx = stop; clks(CPB);
    if (!stop) clks(hold);
    rx = 1'b1; clks(gap);
  endtask

  always @(negedge clk) begin
    if (o_wr) begin
      wr_count++;
      if (expq.size() == 0) begin
        check("unexpected_o_wr", {24'h0, o_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = expq.pop_front();
        check("o_data", {24'h0, o_data}, {24'h0, e[9:2]});
        check("o_frame_err", {31'h0, o_frame_err}, {31'h0, e[1]});
        check("o_parity_err", {31'h0, o_parity_err}, {31'h0, e[0]});
      end
    end
    if (!rst && !o_wr && o_data !== last_data) hold_viol++;
    last_data = o_data;
  end

  initial begin
    logic [7:0] d;
    logic st;
    int wait_n;
    clks(3);
    check("reset_o_wr", {31'h0, o_wr}, 32'h0);
    check("reset_o_data", {24'h0, o_data}, 32'h0);
    check("reset_frame_err", {31'h0, o_frame_err}, 32'h0);
    check("reset_parity_err", {31'h0, o_parity_err}, 32'h0);
    rst = 1'b0;
    clks(20);

    send_frame(8'h55, 1'b1, ^8'h55, 0, 20, 1'b1);

    rx = 1'b0; clks(4); rx = 1'b1; clks(9);
    send_frame(8'h96, 1'b1, ^8'h96, 0, 20, 1'b1);

    send_frame(8'hA3, 1'b0, ^8'hA3, 40, 20, 1'b1);
    send_frame(8'h3C, 1'b1, ^8'h3C, 0, 20, 1'b1);

    send_frame(8'h00, 1'b1, 1'b0, 0, 0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 0, 20, 1'b1);

    fork
      send_frame(8'h81, 1'b1, ^8'h81, 0, 30, 1'b0);
      begin
        clks(5 * CPB + 8);
        #2 rst = 1'b1;
        #1;
        check("midframe_reset_o_data", {24'h0, o_data}, 32'h0);
        check("midframe_reset_o_wr", {31'h0, o_wr}, 32'h0);
        clks(FBITS * CPB + 4 - (5 * CPB + 8));
        rst = 1'b0;
      end
    join
    send_frame(8'h7E, 1'b1, ^8'h7E, 0, 20, 1'b1);

`ifdef RXUART_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 0, 20, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 0, 20, 1'b1);
`endif

    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, st, 1'($urandom), $urandom_range(0, 40),
                 st ? $urandom_range(0, 20) : 20, 1'b1);
    end

    wait_n = 0;
    while (expq.size() != 0 && wait_n < 2000) begin clks(1); wait_n++; end
    clks(10);
    check("queue_drained", expq.size(), 32'h0);
    check("o_wr_count", wr_count, pushed);
    check("hold_violations", hold_viol, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rxuart.md
RXUART -- requirements
Module: rxuart

Interface
REQ-001 SHALL provide parameter CLOCKS_PER_BAUD, default 16'd868, meaning system clocks per UART bit period (legal range 4..65535).
REQ-002 SHALL provide port i_clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port i_uart_rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL provide port o_wr  output  1  one-cycle strobe: o_data holds a newly received byte.
REQ-006 SHALL provide port o_data  output  8  last received byte; held until the next o_wr.
REQ-007 SHALL provide port o_frame_err  output  1  stop bit of the last frame sampled low; valid with o_wr.
REQ-008 SHALL provide port o_parity_err  output  1  parity mismatch on the last frame; valid with o_wr.

Function
REQ-009 SHALL pass i_uart_rx through a 2-flop synchronizer; every sampling decision uses the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, BIT0..BIT7, PARITY (macro only), STOP, WAIT_HIGH.
REQ-011 IDLE: the first cycle rx_s==0 SHALL load the baud counter with (CLOCKS_PER_BAUD>>1)-1 and enter START.
REQ-012 The 16-bit baud counter SHALL decrement each cycle outside IDLE/WAIT_HIGH; a sample occurs on the cycle it equals 0, after which it reloads with CLOCKS_PER_BAUD-1.
REQ-013 START sample: rx_s==1 SHALL return to IDLE with no output (glitch rejection); rx_s==0 SHALL advance to BIT0.
REQ-014 BITn sample SHALL shift rx_s into the data register LSB-first and advance; BIT7 advances to PARITY if enabled, else STOP.
REQ-015 STOP sample SHALL, on the next edge, assert o_wr for exactly one cycle, update o_data, set o_frame_err = !rx_s and o_parity_err per REQ-022.
REQ-016 After STOP: rx_s==1 at the sample SHALL enter IDLE; rx_s==0 SHALL enter WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until rx_s==1, then enter IDLE; no start bit is detected while in WAIT_HIGH (break/line-low lockout).
REQ-018 A new start bit SHALL be accepted on the first cycle of IDLE, permitting back-to-back frames with a single stop bit.
REQ-019 o_wr SHALL never assert for a frame aborted at START; o_data and error flags SHALL change only together with o_wr.
REQ-020 Latency: o_wr SHALL assert 3 cycles after the stop-bit sample point of i_uart_rx (2 sync + 1 register).

Reset
REQ-021 i_reset SHALL asynchronously force state=IDLE, synchronizer flops=1, counter=0, o_wr=0, o_data=8'h00, o_frame_err=0, o_parity_err=0; reset mid-frame discards the partial byte with no o_wr.

Configuration
REQ-022 Macro RXUART_PARITY_EN defined: SHALL expect one even-parity bit after BIT7; o_parity_err = XOR(data bits, parity bit) at o_wr.
REQ-023 RXUART_PARITY_EN undefined: SHALL omit the PARITY state (8N1 frame) and tie o_parity_err to 0.

Verification (CLOCKS_PER_BAUD=16)
REQ-024 Send 8N1 byte 0x55 -> exactly one o_wr, o_data=0x55, o_frame_err=0, o_parity_err=0.
REQ-025 Drive i_uart_rx low for 4 clocks then high -> no o_wr, FSM back in IDLE within 9 clocks.
REQ-026 Send 0xA3 with stop bit low, hold line low 40 clocks, then send 0x3C -> o_wr with 0xA3 and o_frame_err=1; no frame during the low hold; then o_wr with 0x3C, o_frame_err=0.
REQ-027 Send 0x00 then 0xFF back-to-back, one stop bit each -> two o_wr pulses, o_data 0x00 then 0xFF.
REQ-028 Assert i_reset during BIT4 of 0x81, release, then send 0x7E -> no o_wr for 0x81; one o_wr with 0x7E.
REQ-029 With RXUART_PARITY_EN: send 0x01 with parity bit 0 -> o_parity_err=1; resend with parity bit 1 -> o_parity_err=0.
